mem_arbiter: RTL and testbench

Shares one memory port between the core's instruction-fetch path and its load/store path, so a single unified memory can replace the separate instruction and data memories. Each requester uses a req/gnt/rvalid handshake; the arbiter keeps at most one memory transaction outstanding. It sits between the core's fetch/data-access logic and the memory model or on-chip RAM.

---
 rtl/core_bus_pkg.sv | 23 ++
 rtl/bus_timeout.sv | 37 +++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// core_bus_pkg
//   Shared types and default widths for the core-to-memory bus: arbiter
//   state encoding, transaction owner, and default parameter values used by
//   mem_arbiter and bus_timeout.
package core_bus_pkg;

    localparam int ADDR_W_DEF          = 32;
    localparam int DATA_W_DEF          = 32;
    localparam int MAX_DATA_STREAK_DEF = 4;
    localparam int TIMEOUT_DEF         = 255;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

endpackage

// File: rtl/bus_timeout.sv
// bus_timeout
//   Cycle counter that bounds how long one memory transaction may stay
//   outstanding.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     clr       - restart the count (asserted when a transaction is granted)
//     en        - count this cycle (transaction outstanding)
//     expired   - high during the LIMIT-th enabled cycle since the last clear
module bus_timeout
    import core_bus_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of enabled cycles already completed, so the
    // cycle that sees LIMIT-1 is the last one allowed.
    assign expired = en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between instruction fetch (if_*) and load/store
//   (dm_*). One transaction outstanding at a time; data side has priority
//   except when it has already won MAX_DATA_STREAK grants in a row while a
//   fetch was waiting.
//   Ports:
//     clk, rst             - clock, synchronous active-high reset
//     if_req/if_addr       - fetch request, held until if_gnt
//     if_gnt/if_rvalid/if_rdata - fetch grant pulse and response
//     dm_req/dm_we/dm_addr/dm_wdata/dm_fn3 - data request, held until dm_gnt
//     dm_gnt/dm_rvalid/dm_rdata - data grant pulse and completion
//     mem_req/mem_we/mem_addr/mem_wdata/mem_fn3 - memory request + payload
//     mem_ready/mem_rvalid/mem_rdata - memory accept and response
//     bus_err              - sticky, set when a transaction times out
module mem_arbiter
    import core_bus_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF,
    parameter int TIMEOUT         = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_fn3,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_fn3,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);

    arb_state_t        state;
    owner_t            owner;
    logic [SW-1:0]     streak;
    logic              streak_full;
    logic              grant_if, grant_dm;
    logic              tmo_expired, tmo_abort;
    logic              rsp_fire;
    logic [DATA_W-1:0] rsp_data;

    assign streak_full = (streak == SW'(MAX_DATA_STREAK));

    // Grants are combinational so the requester sees gnt in the same cycle
    // it is selected; suppressed while rst is high so nothing is latched.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == ARB_IDLE && !rst) begin
            if (dm_req && !(if_req && streak_full)) grant_dm = 1'b1;
            else if (if_req)                        grant_if = 1'b1;
        end
    end

    assign if_gnt = grant_if;
    assign dm_gnt = grant_dm;

    bus_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant_if | grant_dm),
        .en      (state != ARB_IDLE),
        .expired (tmo_expired)
    );

    // A real response landing on the expiry cycle still wins over the abort.
    always_comb begin
        rsp_fire  = 1'b0;
        rsp_data  = '0;
        tmo_abort = 1'b0;
        if (state == ARB_WAIT && mem_rvalid) begin
            rsp_fire = 1'b1;
            rsp_data = mem_we ? '0 : mem_rdata;
        end else if (tmo_expired) begin
            rsp_fire  = 1'b1;
            tmo_abort = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= OWN_IF;
            streak    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_fn3   <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rvalid <= 1'b0;
            dm_rdata  <= '0;
            bus_err   <= 1'b0;
        end else begin
            // Response outputs are single-cycle pulses routed to the owner.
            if_rvalid <= rsp_fire && (owner == OWN_IF);
            dm_rvalid <= rsp_fire && (owner == OWN_DM);
            if_rdata  <= (rsp_fire && owner == OWN_IF) ? rsp_data : '0;
            dm_rdata  <= (rsp_fire && owner == OWN_DM) ? rsp_data : '0;
            bus_err   <= bus_err | tmo_abort;

            unique case (state)
                ARB_IDLE: begin
                    if (grant_dm) begin
                        owner     <= OWN_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_fn3   <= dm_fn3;
                        state     <= ARB_ISSUE;
                        // Only a data win over a waiting fetch counts toward starvation.
                        if (!if_req)          streak <= '0;
                        else if (!streak_full) streak <= streak + SW'(1);
                    end else if (grant_if) begin
                        owner     <= OWN_IF;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_fn3   <= 3'b000;
                        state     <= ARB_ISSUE;
                        streak    <= '0;
                    end
                end
                ARB_ISSUE: begin
                    if (tmo_abort) begin
                        mem_req <= 1'b0;
                        state   <= ARB_IDLE;
                    end else if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (rsp_fire) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed checks for the fetch, store, timeout and reset scenarios, plus
//   a randomized phase scored against a transaction-timeline model: each
//   grant plans its acceptance, response and completion cycles, and the
//   memory side of the bench drives mem_ready/mem_rvalid on exactly those
//   cycles (with noise where the arbiter must ignore it).
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0, dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [2:0]    dm_fn3 = '0;
    logic          dm_gnt, dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [2:0]    mem_fn3;
    logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    // timeline model state
    int            cyc_no = 0;
    bit            have_txn = 0, own_dm = 0, own_we = 0;
    int            acc_at = 0, rsp_at = 0, free_at = 0, streak = 0;
    logic [AW-1:0] own_addr = '0;
    logic [DW-1:0] own_wdata = '0, exp_rdata = '0;
    logic [2:0]    own_fn3 = '0;
    logic [15:0]   obits = '0;
    int            ngr = 0;

    mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DATA_STREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_fn3(dm_fn3), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_fn3(mem_fn3),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .bus_err(bus_err)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        have_txn = 0; streak = 0; ngr = 0; obits = '0;
    endtask

    // starve=1: both sides request every cycle, memory answers best-case.
    task automatic run(input int ncyc, input bit starve);
        bit gi_last = 0, gd_last = 0;
        bit e_gif, e_gdm, e_ifv, e_dmv, e_mreq;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            cyc_no++;
            if (gi_last) if_req = 1'b0;
            if (gd_last) dm_req = 1'b0;
            if (!if_req && (starve || $urandom_range(0, 2) == 0)) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dm_req && (starve || $urandom_range(0, 2) == 0)) begin
                dm_req   = 1'b1;
                dm_we    = starve ? 1'b0 : 1'($urandom_range(0, 1));
                dm_addr  = $urandom;
                dm_wdata = $urandom;
                dm_fn3   = 3'($urandom_range(0, 7));
            end
            mem_rdata = $urandom;
            if (have_txn && cyc_no <= acc_at) mem_ready = (cyc_no == acc_at);
            else                              mem_ready = 1'($urandom_range(0, 1));
            if (have_txn && cyc_no > acc_at && cyc_no <= rsp_at) mem_rvalid = (cyc_no == rsp_at);
            else                                                 mem_rvalid = ($urandom_range(0, 3) == 0);
            if (have_txn && cyc_no == rsp_at) exp_rdata = own_we ? '0 : mem_rdata;
            #1;
            e_mreq = have_txn && cyc_no <= acc_at;
            e_ifv = 0; e_dmv = 0;
            if (have_txn && cyc_no == free_at) begin
                e_ifv = !own_dm; e_dmv = own_dm; have_txn = 0;
            end
            e_gif = 0; e_gdm = 0;
            if (!have_txn) begin
                if (dm_req && !(if_req && streak == MAXS)) e_gdm = 1;
                else if (if_req)                           e_gif = 1;
            end
            chk("rnd_if_gnt", 64'(if_gnt), 64'(e_gif));
            chk("rnd_dm_gnt", 64'(dm_gnt), 64'(e_gdm));
            chk("rnd_mem_req", 64'(mem_req), 64'(e_mreq));
            if (e_mreq) begin
                chk("rnd_mem_addr", 64'(mem_addr), 64'(own_addr));
                chk("rnd_mem_we", 64'(mem_we), 64'(own_we));
                chk("rnd_mem_fn3", 64'(mem_fn3), 64'(own_fn3));
                if (own_we) chk("rnd_mem_wdata", 64'(mem_wdata), 64'(own_wdata));
            end
            chk("rnd_if_rvalid", 64'(if_rvalid), 64'(e_ifv));
            chk("rnd_dm_rvalid", 64'(dm_rvalid), 64'(e_dmv));
            if (e_ifv) chk("rnd_if_rdata", 64'(if_rdata), 64'(exp_rdata));
            if (e_dmv) chk("rnd_dm_rdata", 64'(dm_rdata), 64'(exp_rdata));
            if (if_gnt || dm_gnt) begin
                if (ngr < 10) obits = {obits[14:0], dm_gnt};
                ngr++;
            end
            if (e_gif || e_gdm) begin
                have_txn  = 1;
                own_dm    = e_gdm;
                own_we    = e_gdm && dm_we;
                own_addr  = e_gdm ? dm_addr : if_addr;
                own_fn3   = e_gdm ? dm_fn3 : 3'b000;
                own_wdata = dm_wdata;
                acc_at    = cyc_no + 1 + (starve ? 0 : int'($urandom_range(0, 3)));
                rsp_at    = acc_at + (starve ? 1 : int'($urandom_range(1, 3)));
                free_at   = rsp_at + 1;
                if (e_gdm && if_req) streak = (streak < MAXS) ? streak + 1 : streak;
                else                 streak = 0;
            end
            gi_last = e_gif; gd_last = e_gdm;
        end
    endtask

    initial begin
        int early;

        // reset state
        step(); #1;
        chk("rst_if_gnt", 64'(if_gnt), 64'(0));
        chk("rst_dm_gnt", 64'(dm_gnt), 64'(0));
        chk("rst_if_rvalid", 64'(if_rvalid), 64'(0));
        chk("rst_dm_rvalid", 64'(dm_rvalid), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_bus_err", 64'(bus_err), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_if_rdata", 64'(if_rdata), 64'(0));
        chk("rst_dm_rdata", 64'(dm_rdata), 64'(0));

        // lone fetch, best-case memory
        step(); rst = 1'b0; if_req = 1'b1; if_addr = 32'h8000_0000; mem_ready = 1'b1; #1;
        chk("lone_if_gnt", 64'(if_gnt), 64'(1));
        chk("lone_dm_gnt", 64'(dm_gnt), 64'(0));
        chk("lone_mreq_c0", 64'(mem_req), 64'(0));
        step(); if_req = 1'b0; #1;
        chk("lone_mreq_c1", 64'(mem_req), 64'(1));
        chk("lone_maddr", 64'(mem_addr), 64'(32'h8000_0000));
        chk("lone_mwe", 64'(mem_we), 64'(0));
        chk("lone_mfn3", 64'(mem_fn3), 64'(0));
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; #1;
        chk("lone_mreq_c2", 64'(mem_req), 64'(0));
        chk("lone_rvalid_c2", 64'(if_rvalid), 64'(0));
        step(); mem_rvalid = 1'b0; #1;
        chk("lone_rvalid_c3", 64'(if_rvalid), 64'(1));
        chk("lone_rdata", 64'(if_rdata), 64'(32'h0000_0013));
        chk("lone_dm_rvalid", 64'(dm_rvalid), 64'(0));
        chk("lone_dm_rdata", 64'(dm_rdata), 64'(0));
        step(); #1;
        chk("lone_rvalid_pulse", 64'(if_rvalid), 64'(0));

        // randomized traffic against the timeline model
        do_reset();
        run(400, 1'b0);
        chk("rnd_no_bus_err", 64'(bus_err), 64'(0));

        // starvation: D D D D I repeating (1 = data grant)
        do_reset();
        run(30, 1'b1);
        chk("starve_count", 64'(ngr), 64'(10));
        chk("starve_seq", 64'(obits[9:0]), 64'(10'b1111011110));

        // store with mem_ready delayed three cycles
        do_reset();
        step(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h8000_2000;
        dm_wdata = 32'hDEAD_BEEF; dm_fn3 = 3'b010; #1;
        chk("st_dm_gnt", 64'(dm_gnt), 64'(1));
        chk("st_if_gnt", 64'(if_gnt), 64'(0));
        for (int i = 0; i < 4; i++) begin
            step(); dm_req = 1'b0; mem_ready = (i == 3); #1;
            chk("st_mreq", 64'(mem_req), 64'(1));
            chk("st_mwe", 64'(mem_we), 64'(1));
            chk("st_maddr", 64'(mem_addr), 64'(32'h8000_2000));
            chk("st_mwdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
            chk("st_mfn3", 64'(mem_fn3), 64'(3'b010));
        end
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        chk("st_mreq_wait", 64'(mem_req), 64'(0));
        chk("st_rvalid_early", 64'(dm_rvalid), 64'(0));
        step(); mem_rvalid = 1'b0; #1;
        chk("st_dm_rvalid", 64'(dm_rvalid), 64'(1));
        chk("st_dm_rdata", 64'(dm_rdata), 64'(0));
        chk("st_if_rvalid", 64'(if_rvalid), 64'(0));

        // timeout: accepted, response never comes
        step(); dm_we = 1'b0; if_req = 1'b1; if_addr = 32'h8000_0040; mem_ready = 1'b1; #1;
        chk("tmo_gnt", 64'(if_gnt), 64'(1));
        early = 0;
        for (int k = 1; k <= TMO; k++) begin
            step(); if_req = 1'b0; mem_ready = (k == 1); #1;
            if (if_rvalid || dm_rvalid || bus_err || (mem_req !== (k == 1))) early++;
        end
        chk("tmo_quiet_cycles", 64'(early), 64'(0));
        step(); mem_ready = 1'b0; #1;
        chk("tmo_if_rvalid", 64'(if_rvalid), 64'(1));
        chk("tmo_if_rdata", 64'(if_rdata), 64'(0));
        chk("tmo_bus_err", 64'(bus_err), 64'(1));
        chk("tmo_mreq", 64'(mem_req), 64'(0));
        step(); mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; #1;
        chk("tmo_rvalid_pulse", 64'(if_rvalid), 64'(0));
        step(); mem_rvalid = 1'b0; #1;
        chk("tmo_stray_if", 64'(if_rvalid), 64'(0));
        chk("tmo_stray_dm", 64'(dm_rvalid), 64'(0));
        chk("tmo_err_sticky", 64'(bus_err), 64'(1));

        // reset while in WAIT
        step(); if_req = 1'b1; if_addr = 32'h8000_0080; mem_ready = 1'b1; #1;
        chk("rw_gnt", 64'(if_gnt), 64'(1));
        step(); if_req = 1'b0; #1;
        chk("rw_mreq", 64'(mem_req), 64'(1));
        step(); mem_ready = 1'b0; rst = 1'b1; #1;
        chk("rw_in_wait", 64'(mem_req), 64'(0));
        step(); rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
        chk("rw_if_gnt", 64'(if_gnt), 64'(0));
        chk("rw_dm_gnt", 64'(dm_gnt), 64'(0));
        chk("rw_if_rvalid", 64'(if_rvalid), 64'(0));
        chk("rw_dm_rvalid", 64'(dm_rvalid), 64'(0));
        chk("rw_mreq0", 64'(mem_req), 64'(0));
        chk("rw_mwe", 64'(mem_we), 64'(0));
        chk("rw_bus_err", 64'(bus_err), 64'(0));
        chk("rw_maddr", 64'(mem_addr), 64'(0));
        step(); mem_rvalid = 1'b0; #1;
        chk("rw_no_rvalid", 64'(if_rvalid), 64'(0));
        step(); if_req = 1'b1; if_addr = 32'h8000_0100; mem_ready = 1'b1; #1;
        chk("rw2_gnt", 64'(if_gnt), 64'(1));
        step(); if_req = 1'b0; #1;
        chk("rw2_mreq", 64'(mem_req), 64'(1));
        chk("rw2_maddr", 64'(mem_addr), 64'(32'h8000_0100));
        step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
        step(); mem_rvalid = 1'b0; #1;
        chk("rw2_rvalid", 64'(if_rvalid), 64'(1));
        chk("rw2_rdata", 64'(if_rdata), 64'(32'hCAFE_F00D));
        chk("rw2_bus_err", 64'(bus_err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
